axi_req_sched: RTL and testbench
================================

# axi_req_sched

Request scheduler placed between the CPU's two SRAM-like ports (instruction fetch, data load/store) and the AXI bridge command side. It arbitrates both requesters onto one registered command stream, limits outstanding transactions per requester, enforces load/store ordering on the data port, and routes returning responses back to the right requester as `data_ok`. Downstream, the bridge converts `cmd_*` into AR/AW/W beats and returns one `rsp_*` beat per command.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width. `wstrb` is `DATA_W/8` bits.
- `MAX_OUT`, 2, maximum outstanding transactions per counter. Range 1..7.
- `STARVE_LIM`, 4, number of consecutive data grants, made while inst is eligible, after which inst wins. Range 1..15.
- `clk`  in  1  clock, all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_req`  in  1  instruction read request.
- `inst_addr`  in  ADDR_W  fetch address.
- `inst_size`  in  2  log2 bytes.
- `inst_addr_ok`  out  1  request accepted this cycle.
- `inst_data_ok`  out  1  read data valid.
- `inst_rdata`  out  DATA_W  read data.
- `data_req`, `data_wr`  in  1 each  data request and write flag.
- `data_addr`  in  ADDR_W  data address.
- `data_size`  in  2  log2 bytes.
- `data_wstrb`  in  DATA_W/8  byte strobes.
- `data_wdata`  in  DATA_W  write data.
- `data_addr_ok`, `data_data_ok`  out  1 each  accept strobe and completion strobe.
- `data_rdata`  out  DATA_W  load data.
- `cmd_valid`  out  1  command valid.
- `cmd_ready`  in  1  bridge accepts the command.
- `cmd_id`  out  1  0 = inst, 1 = data.
- `cmd_wr`, `cmd_addr`, `cmd_size`, `cmd_wstrb`, `cmd_wdata`  out  command fields.
- `rsp_valid`  in  1  response valid.
- `rsp_id`, `rsp_wr`  in  1 each  response source id and write flag.
- `rsp_data`  in  DATA_W  read data; don't-care when `rsp_wr` is 1.
- `rsp_ready`  out  1  tied to 1.
- `err_unexp`  out  1  sticky flag: a response arrived with no matching outstanding transaction.

## Operation
- Command slot is one register with two states.
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on `cmd_ready` with no new grant.
  - FULL stays FULL on `cmd_ready` with a new grant; this gives back-to-back issue.
- A grant is possible only when `slot_free = !cmd_valid | cmd_ready`.
- Counters: `inst_cnt`, `drd_cnt`, `dwr_cnt`, each `clog2(MAX_OUT+1)` bits.
  - Increment on grant of the matching type.
  - Decrement on `rsp_valid` with matching `rsp_id`/`rsp_wr`.
  - Increment and decrement in the same cycle leave the counter unchanged.
- Eligibility:
  - inst: `inst_req & inst_cnt<MAX_OUT`.
  - data read: `data_req & !data_wr & drd_cnt<MAX_OUT & dwr_cnt==0`.
  - data write: `data_req & data_wr & dwr_cnt<MAX_OUT & drd_cnt==0`.
  - Reads and writes never overlap in flight. This preserves RAW and WAR ordering.
- Arbitration: data wins, except when `starve_cnt==STARVE_LIM` and inst is eligible; then inst wins.
  - `starve_cnt` increments, saturating, on each data grant in a cycle where inst was also eligible.
  - `starve_cnt` clears on an inst grant.
- `inst_addr_ok` / `data_addr_ok` = grant & `slot_free` & `resetn`, combinational. The winner's fields load into `cmd_*`.
- Response routing is combinational, zero latency:
  - `rsp_valid & !rsp_id` -> `inst_data_ok=1`, `inst_rdata=rsp_data`.
  - `rsp_id=1` -> `data_data_ok=1`, `data_rdata=rsp_data`.
- Unexpected response: `rsp_valid` while the matching counter is 0.
  - No `data_ok`, no underflow; `err_unexp` is set until reset.
  - An `rsp_id=0` response with `rsp_wr=1` is always unexpected.

## Timing
- Reset values: `cmd_valid=0`, all `cmd_*` fields 0, all counters 0, `starve_cnt=0`, `err_unexp=0`. The `addr_ok` outputs are 0 while `resetn=0`.
- Reset asserted mid-operation clears the slot and counters immediately. In-flight responses after reset count as unexpected.
- A request accepted in cycle T (`addr_ok=1`) gives `cmd_valid=1` with its fields at T+1.
- `cmd_*` hold stable while `cmd_valid & !cmd_ready`.
- With `cmd_ready` held at 1, throughput is one grant per cycle.
- A response in cycle T frees its counter slot for a grant in cycle T (same-cycle reuse).
- A requester holds `req` and its fields until it sees `addr_ok`.

## Test plan
- **Single load:** `data_req`, `data_wr=0`, `addr=0x100`, `cmd_ready=1`; response `id=1`, `data=0xDEADBEEF` at T+3 -> `data_addr_ok` at T, `cmd_valid` with `cmd_addr=0x100`, `cmd_id=1` at T+1, `data_data_ok` with `data_rdata=0xDEADBEEF` at T+3.
- **Starvation bound:** both requesters request continuously with `cmd_ready=1` and responses returned every cycle -> grant pattern is 4 data then 1 inst, repeating.
- **Ordering:** store to `0x200` outstanding, then a load is requested -> no `data_addr_ok` until the write response. The load is granted in the same cycle as that response.
- **Limit:** 3 inst requests with no responses, `MAX_OUT=2` -> only 2 `inst_addr_ok`. The third is granted in the cycle of the first response.
- **Backpressure:** `cmd_ready=0` for 5 cycles -> `cmd_*` stable and no further `addr_ok` during those cycles.
- **Unexpected response and reset:** `rsp_valid`, `rsp_id=0` with `inst_cnt=0` -> no `inst_data_ok`, `err_unexp=1`. Then assert `resetn` low mid-command -> `cmd_valid=0` and `err_unexp=0` without waiting for a clock edge.

Source files
------------

// File: rtl/axi_req_sched.sv
// axi_req_sched
//   Arbitrates the CPU instruction-fetch port and the data load/store port
//   onto a single registered command stream for the AXI bridge. It caps the
//   number of outstanding transactions per requester, keeps loads and stores
//   from overlapping in flight, and routes each returning response to its
//   requester.
// Ports
//   clk, resetn               clock, asynchronous active-low reset
//   inst_*                    fetch request in, addr_ok/data_ok/rdata out
//   data_*                    load/store request in, addr_ok/data_ok/rdata out
//   cmd_*                     registered command to the bridge (valid/ready)
//   rsp_*                     one response beat per command from the bridge
//   err_unexp                 sticky: a response arrived with nothing outstanding
module axi_req_sched #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_OUT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [1:0]          inst_size,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic                cmd_id,
    output logic                cmd_wr,
    output logic [ADDR_W-1:0]   cmd_addr,
    output logic [1:0]          cmd_size,
    output logic [DATA_W/8-1:0] cmd_wstrb,
    output logic [DATA_W-1:0]   cmd_wdata,
    input  logic                rsp_valid,
    input  logic                rsp_id,
    input  logic                rsp_wr,
    input  logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_ready,
    output logic                err_unexp
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int BW = DATA_W / 8;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;

    slot_e             slot_q, slot_d;
    logic              cmd_id_q, cmd_id_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [1:0]        cmd_size_q, cmd_size_d;
    logic [BW-1:0]     cmd_wstrb_q, cmd_wstrb_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [CW-1:0]     inst_cnt_q, inst_cnt_d;
    logic [CW-1:0]     drd_cnt_q, drd_cnt_d;
    logic [CW-1:0]     dwr_cnt_q, dwr_cnt_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic              err_unexp_q, err_unexp_d;

    logic          slot_free;
    logic          inst_dec, drd_dec, dwr_dec, unexp;
    logic [CW-1:0] inst_eff, drd_eff, dwr_eff;
    logic          inst_elig, data_elig, inst_win, data_win;
    logic          grant_i, grant_d;

    // Responses are only honoured against a non-zero counter, so a stray beat
    // never underflows. Fetches are never writes, so id 0 with wr 1 is stray.
    assign inst_dec = rsp_valid & ~rsp_id & ~rsp_wr & (inst_cnt_q != '0);
    assign drd_dec  = rsp_valid &  rsp_id & ~rsp_wr & (drd_cnt_q  != '0);
    assign dwr_dec  = rsp_valid &  rsp_id &  rsp_wr & (dwr_cnt_q  != '0);
    assign unexp    = rsp_valid & ~(inst_dec | drd_dec | dwr_dec);

    // Eligibility looks at counts after this cycle's response, so a returning
    // beat frees its slot for a grant in the same cycle.
    assign inst_eff = inst_cnt_q - CW'(inst_dec);
    assign drd_eff  = drd_cnt_q  - CW'(drd_dec);
    assign dwr_eff  = dwr_cnt_q  - CW'(dwr_dec);

    assign inst_elig = inst_req & (inst_eff < CW'(MAX_OUT));
    // Loads and stores never overlap in flight, which keeps RAW/WAR order.
    assign data_elig = data_req & (data_wr ? ((dwr_eff < CW'(MAX_OUT)) & (drd_eff == '0))
                                           : ((drd_eff < CW'(MAX_OUT)) & (dwr_eff == '0)));

    assign inst_win = inst_elig & (~data_elig | (starve_cnt_q == SW'(STARVE_LIM)));
    assign data_win = data_elig & ~inst_win;

    assign slot_free = (slot_q == EMPTY) | cmd_ready;
    assign grant_i   = inst_win & slot_free & resetn;
    assign grant_d   = data_win & slot_free & resetn;

    always_comb begin
        slot_d       = slot_q;
        cmd_id_d     = cmd_id_q;
        cmd_wr_d     = cmd_wr_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_size_d   = cmd_size_q;
        cmd_wstrb_d  = cmd_wstrb_q;
        cmd_wdata_d  = cmd_wdata_q;
        starve_cnt_d = starve_cnt_q;

        if (grant_i) begin
            slot_d      = FULL;
            cmd_id_d    = 1'b0;
            cmd_wr_d    = 1'b0;
            cmd_addr_d  = inst_addr;
            cmd_size_d  = inst_size;
            cmd_wstrb_d = '0;
            cmd_wdata_d = '0;
        end else if (grant_d) begin
            slot_d      = FULL;
            cmd_id_d    = 1'b1;
            cmd_wr_d    = data_wr;
            cmd_addr_d  = data_addr;
            cmd_size_d  = data_size;
            cmd_wstrb_d = data_wstrb;
            cmd_wdata_d = data_wdata;
        end else if (cmd_ready) begin
            slot_d = EMPTY;
        end

        if (grant_i) begin
            starve_cnt_d = '0;
        end else if (grant_d & inst_elig & (starve_cnt_q != SW'(STARVE_LIM))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        inst_cnt_d  = inst_cnt_q + CW'(grant_i)                - CW'(inst_dec);
        drd_cnt_d   = drd_cnt_q  + CW'(grant_d & ~data_wr)     - CW'(drd_dec);
        dwr_cnt_d   = dwr_cnt_q  + CW'(grant_d &  data_wr)     - CW'(dwr_dec);
        err_unexp_d = err_unexp_q | unexp;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_q       <= EMPTY;
            cmd_id_q     <= 1'b0;
            cmd_wr_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_size_q   <= '0;
            cmd_wstrb_q  <= '0;
            cmd_wdata_q  <= '0;
            inst_cnt_q   <= '0;
            drd_cnt_q    <= '0;
            dwr_cnt_q    <= '0;
            starve_cnt_q <= '0;
            err_unexp_q  <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            cmd_id_q     <= cmd_id_d;
            cmd_wr_q     <= cmd_wr_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_size_q   <= cmd_size_d;
            cmd_wstrb_q  <= cmd_wstrb_d;
            cmd_wdata_q  <= cmd_wdata_d;
            inst_cnt_q   <= inst_cnt_d;
            drd_cnt_q    <= drd_cnt_d;
            dwr_cnt_q    <= dwr_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            err_unexp_q  <= err_unexp_d;
        end
    end

    assign inst_addr_ok = grant_i;
    assign data_addr_ok = grant_d;
    assign inst_data_ok = inst_dec;
    assign data_data_ok = drd_dec | dwr_dec;
    assign inst_rdata   = rsp_data;
    assign data_rdata   = rsp_data;
    assign rsp_ready    = 1'b1;
    assign err_unexp    = err_unexp_q;

    assign cmd_valid = (slot_q == FULL);
    assign cmd_id    = cmd_id_q;
    assign cmd_wr    = cmd_wr_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_size  = cmd_size_q;
    assign cmd_wstrb = cmd_wstrb_q;
    assign cmd_wdata = cmd_wdata_q;
endmodule

// File: tb/tb_axi_req_sched.sv
// Bench for axi_req_sched: per-scenario tasks with inline checks, plus a
// command scoreboard that records each accepted request and compares it with
// the command the DUT later hands to the bridge.
module tb_axi_req_sched;
    typedef struct packed {
        logic        id;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } cmd_t;

    localparam logic [31:0] MASK = 32'hA5A5_0000;

    logic        clk, resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [1:0]  inst_size;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        cmd_valid, cmd_ready, cmd_id, cmd_wr;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic [3:0]  cmd_wstrb;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_id, rsp_wr;
    logic [31:0] rsp_data;
    logic        rsp_ready, err_unexp;

    int   checks = 0;
    int   errors = 0;
    cmd_t cmd_q[$];
    cmd_t flight_q[$];

    axi_req_sched dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wstrb(cmd_wstrb), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_wr(rsp_wr), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .err_unexp(err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Scoreboard: inputs change only right after a falling edge; this samples
    // 1 time unit later, well before the next rising edge.
    always @(negedge clk) begin
        cmd_t got, e;
        #1;
        if (!resetn) begin
            cmd_q.delete();
            flight_q.delete();
        end else begin
            if (cmd_valid && cmd_ready) begin
                got.id = cmd_id; got.wr = cmd_wr; got.addr = cmd_addr;
                got.size = cmd_size; got.wstrb = cmd_wstrb; got.wdata = cmd_wdata;
                checks++;
                if (cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_cmd: got %h with no accepted request", got);
                end else begin
                    e = cmd_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL sb_cmd: got %h expected %h", got, e);
                    end
                    flight_q.push_back(e);
                end
            end
            if (inst_addr_ok) begin
                e.id = 1'b0; e.wr = 1'b0; e.addr = inst_addr; e.size = inst_size;
                e.wstrb = '0; e.wdata = '0;
                cmd_q.push_back(e);
            end
            if (data_addr_ok) begin
                e.id = 1'b1; e.wr = data_wr; e.addr = data_addr; e.size = data_size;
                e.wstrb = data_wstrb; e.wdata = data_wdata;
                cmd_q.push_back(e);
            end
        end
    end

    task automatic idle_inputs();
        inst_req = 0; inst_addr = 0; inst_size = 2'd2;
        data_req = 0; data_wr = 0; data_addr = 0; data_size = 2'd2;
        data_wstrb = 0; data_wdata = 0;
        cmd_ready = 1; rsp_valid = 0; rsp_id = 0; rsp_wr = 0; rsp_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        inst_req = 1; data_req = 1; inst_addr = 32'h44; data_addr = 32'h88;
        @(negedge clk);
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_addr !== 32'h0 || cmd_id !== 1'b0 || cmd_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_cmd: valid=%b addr=%h id=%b wdata=%h, need 0", cmd_valid, cmd_addr, cmd_id, cmd_wdata);
        end
        checks++;
        if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0 || err_unexp !== 1'b0) begin
            errors++; $display("FAIL reset_ok: iok=%b dok=%b err=%b, need 0", inst_addr_ok, data_addr_ok, err_unexp);
        end
        checks++;
        if (rsp_ready !== 1'b1) begin
            errors++; $display("FAIL rsp_ready: got %b need 1", rsp_ready);
        end
        @(negedge clk);
        idle_inputs();
        resetn = 1;
        @(negedge clk);
    endtask

    task automatic test_single_load();
        data_req = 1; data_wr = 0; data_addr = 32'h100; data_size = 2'd2;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL load_addr_ok: got %b need 1", data_addr_ok); end
        @(negedge clk);
        data_req = 0;
        #1;
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 32'h100 || cmd_id !== 1'b1 || cmd_wr !== 1'b0) begin
            errors++; $display("FAIL load_cmd: valid=%b addr=%h id=%b wr=%b need 1/100/1/0", cmd_valid, cmd_addr, cmd_id, cmd_wr);
        end
        @(negedge clk);
        @(negedge clk);
        rsp_valid = 1; rsp_id = 1; rsp_wr = 0; rsp_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'hDEADBEEF || inst_data_ok !== 1'b0) begin
            errors++; $display("FAIL load_rsp: dok=%b rdata=%h iok=%b need 1/deadbeef/0", data_data_ok, data_rdata, inst_data_ok);
        end
        @(negedge clk);
        rsp_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_ordering();
        data_req = 1; data_wr = 1; data_addr = 32'h200; data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL order_store_ok: got %b need 1", data_addr_ok); end
        @(negedge clk);
        data_wr = 0; data_addr = 32'h204; data_wstrb = 0; data_wdata = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL order_load_blocked: cycle %0d got %b need 0", c, data_addr_ok); end
            @(negedge clk);
        end
        rsp_valid = 1; rsp_id = 1; rsp_wr = 1; rsp_data = 32'h0;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1 || data_data_ok !== 1'b1) begin
            errors++; $display("FAIL order_reuse: addr_ok=%b data_ok=%b need 1/1", data_addr_ok, data_data_ok);
        end
        @(negedge clk);
        data_req = 0; rsp_valid = 0;
        @(negedge clk);
        rsp_valid = 1; rsp_id = 1; rsp_wr = 0; rsp_data = 32'h0204_0204;
        #1;
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'h0204_0204) begin
            errors++; $display("FAIL order_load_rsp: ok=%b rdata=%h need 1/02040204", data_data_ok, data_rdata);
        end
        @(negedge clk);
        rsp_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_limit();
        logic took;
        took = 0;
        inst_req = 1; inst_addr = 32'h1000;
        for (int c = 0; c < 5; c++) begin
            if (took) inst_addr = inst_addr + 4;
            #1;
            took = inst_addr_ok;
            checks++;
            if (inst_addr_ok !== (c < 2)) begin
                errors++; $display("FAIL limit_ok: cycle %0d got %b need %b", c, inst_addr_ok, (c < 2));
            end
            @(negedge clk);
        end
        rsp_valid = 1; rsp_id = 0; rsp_wr = 0; rsp_data = 32'h1000 ^ MASK;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b1 || inst_rdata !== (32'h1000 ^ MASK)) begin
            errors++; $display("FAIL limit_reuse: addr_ok=%b data_ok=%b rdata=%h", inst_addr_ok, inst_data_ok, inst_rdata);
        end
        @(negedge clk);
        inst_req = 0;
        for (int c = 0; c < 2; c++) begin
            rsp_data = c;
            #1;
            checks++;
            if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL limit_drain: rsp %0d got %b need 1", c, inst_data_ok); end
            @(negedge clk);
        end
        rsp_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        cmd_ready = 0;
        data_req = 1; data_wr = 1; data_addr = 32'h300; data_size = 2'd1;
        data_wstrb = 4'b0011; data_wdata = 32'hCAFEF00D;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL bp_first_ok: got %b need 1", data_addr_ok); end
        @(negedge clk);
        data_req = 0; data_wr = 0; data_wstrb = 0; data_wdata = 0; data_addr = 0;
        inst_req = 1; inst_addr = 32'h2000;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (cmd_valid !== 1'b1 || cmd_id !== 1'b1 || cmd_wr !== 1'b1 || cmd_addr !== 32'h300 ||
                cmd_size !== 2'd1 || cmd_wstrb !== 4'b0011 || cmd_wdata !== 32'hCAFEF00D) begin
                errors++; $display("FAIL bp_hold: cycle %0d valid=%b addr=%h wdata=%h strb=%b", c, cmd_valid, cmd_addr, cmd_wdata, cmd_wstrb);
            end
            checks++;
            if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
                errors++; $display("FAIL bp_no_grant: cycle %0d iok=%b dok=%b need 0", c, inst_addr_ok, data_addr_ok);
            end
            @(negedge clk);
        end
        cmd_ready = 1;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL bp_release: got %b need 1", inst_addr_ok); end
        @(negedge clk);
        inst_req = 0;
        rsp_valid = 1; rsp_id = 1; rsp_wr = 1; rsp_data = 0;
        #1;
        checks++;
        if (data_data_ok !== 1'b1) begin errors++; $display("FAIL bp_wr_rsp: got %b need 1", data_data_ok); end
        @(negedge clk);
        rsp_id = 0; rsp_wr = 0; rsp_data = 32'h2000 ^ MASK;
        #1;
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== (32'h2000 ^ MASK)) begin
            errors++; $display("FAIL bp_inst_rsp: ok=%b rdata=%h", inst_data_ok, inst_rdata);
        end
        @(negedge clk);
        rsp_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        cmd_t e;
        logic took_i, took_d, want_i;
        int   ng;
        do_reset();
        took_i = 0; took_d = 0; ng = 0;
        inst_req = 1; inst_addr = 32'h3000;
        data_req = 1; data_wr = 0; data_addr = 32'h5000;
        for (int c = 0; c < 20; c++) begin
            if (took_i) inst_addr = inst_addr + 4;
            if (took_d) data_addr = data_addr + 4;
            if (flight_q.size() > 0) begin
                e = flight_q.pop_front();
                rsp_valid = 1; rsp_id = e.id; rsp_wr = e.wr; rsp_data = e.addr ^ MASK;
            end else begin
                rsp_valid = 0;
            end
            #1;
            if (rsp_valid) begin
                checks++;
                if (e.id ? (data_data_ok !== 1'b1 || data_rdata !== (e.addr ^ MASK))
                         : (inst_data_ok !== 1'b1 || inst_rdata !== (e.addr ^ MASK))) begin
                    errors++; $display("FAIL starve_rsp: id=%b iok=%b dok=%b", e.id, inst_data_ok, data_data_ok);
                end
            end
            took_i = inst_addr_ok; took_d = data_addr_ok;
            want_i = (ng % 5 == 4);
            checks++;
            if (took_i !== want_i || took_d !== !want_i) begin
                errors++; $display("FAIL starve_pattern: grant %0d iok=%b dok=%b need inst=%b", ng, took_i, took_d, want_i);
            end
            ng++;
            @(negedge clk);
        end
        inst_req = 0; data_req = 0;
        for (int c = 0; c < 8; c++) begin
            if (flight_q.size() > 0) begin
                e = flight_q.pop_front();
                rsp_valid = 1; rsp_id = e.id; rsp_wr = e.wr; rsp_data = e.addr ^ MASK;
            end else begin
                rsp_valid = 0;
            end
            #1;
            if (rsp_valid) begin
                checks++;
                if ((e.id ? data_data_ok : inst_data_ok) !== 1'b1) begin
                    errors++; $display("FAIL starve_drain: id=%b data_ok missing", e.id);
                end
            end
            @(negedge clk);
        end
        rsp_valid = 0;
        checks++;
        if (flight_q.size() != 0 || cmd_q.size() != 0 || err_unexp !== 1'b0) begin
            errors++; $display("FAIL starve_clean: flight=%0d pending=%0d err=%b need 0/0/0", flight_q.size(), cmd_q.size(), err_unexp);
        end
        @(negedge clk);
    endtask

    task automatic test_unexp_reset();
        rsp_valid = 1; rsp_id = 0; rsp_wr = 0; rsp_data = 32'h1;
        #1;
        checks++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            errors++; $display("FAIL unexp_no_ok: iok=%b dok=%b need 0", inst_data_ok, data_data_ok);
        end
        @(negedge clk);
        rsp_valid = 0;
        cmd_ready = 0; data_req = 1; data_wr = 0; data_addr = 32'h400;
        #1;
        checks++;
        if (err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_flag: got %b need 1", err_unexp); end
        @(negedge clk);
        #1;
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 32'h400) begin
            errors++; $display("FAIL unexp_cmd: valid=%b addr=%h need 1/400", cmd_valid, cmd_addr);
        end
        #2;
        resetn = 0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || err_unexp !== 1'b0 || cmd_addr !== 32'h0 || data_addr_ok !== 1'b0) begin
            errors++; $display("FAIL async_reset: valid=%b err=%b addr=%h dok=%b need 0", cmd_valid, err_unexp, cmd_addr, data_addr_ok);
        end
        @(negedge clk);
        data_req = 0; cmd_ready = 1;
        resetn = 1;
        @(negedge clk);
        rsp_valid = 1; rsp_id = 1; rsp_wr = 0; rsp_data = 32'h400;
        #1;
        checks++;
        if (data_data_ok !== 1'b0) begin errors++; $display("FAIL stale_rsp: got %b need 0", data_data_ok); end
        @(negedge clk);
        rsp_valid = 0;
        #1;
        checks++;
        if (err_unexp !== 1'b1) begin errors++; $display("FAIL stale_flag: got %b need 1", err_unexp); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_ordering();
        test_limit();
        test_backpressure();
        test_starvation();
        test_unexp_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
